// File: rtl/pram_loader_defs.sv
// Shared definitions for the program-RAM image loader: FSM encoding, error causes
// and image-size limits.
package pram_loader_defs;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DAT_HI = 3'd3,
      S_DAT_LO = 3'd4,
      S_CHK    = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_LEN  = 2'd1,
      ERR_CHK  = 2'd2,
      ERR_OVR  = 2'd3
   } err_code_t;

   localparam int unsigned DEFAULT_ADR_WL = 12;
   localparam int unsigned MAX_WORDS      = 2 ** DEFAULT_ADR_WL;

   function automatic int unsigned max_words(input int unsigned adr_wl);
      return 32'd1 << adr_wl;
   endfunction

endpackage

// File: rtl/pram_loader_asm.sv
// Byte-to-word assembler: holds the high byte, accumulates the data checksum and
// emits the registered one-cycle write ack together with the assembled word.
module pram_loader_asm #(
   parameter int data_wl = 16
) (
   input  logic               clk,
   input  logic               a_reset,
   input  logic               chk_clr,
   input  logic               hi_we,
   input  logic               lo_we,
   input  logic [7:0]         rx_data_in,
   output logic [data_wl-1:0] data_out,
   output logic               init_ack_out,
   output logic [7:0]         checksum
);

   logic [7:0]         hi_q;
   logic [7:0]         chk_q;
   logic [data_wl-1:0] data_q;
   logic               ack_q;

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         hi_q   <= '0;
         chk_q  <= '0;
         data_q <= '0;
         ack_q  <= 1'b0;
      end else begin
         ack_q <= lo_we;
         if (chk_clr)
            chk_q <= '0;
         else if (hi_we || lo_we)
            chk_q <= chk_q ^ rx_data_in;
         if (hi_we)
            hi_q <= rx_data_in;
         if (lo_we)
            data_q <= data_wl'({hi_q, rx_data_in});
      end
   end

   assign data_out     = data_q;
   assign init_ack_out = ack_q;
   assign checksum     = chk_q;

endmodule

// File: rtl/pram_loader.sv
// Framed program-image loader: parses LEN_HI LEN_LO {HI LO}*N CHK from the byte
// link, drives the pram_adr_cnt init interface and reports done / error.
//
// state  | meaning
// IDLE   | waiting for start_load_in
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte, range check
// DAT_HI | waiting for data word high byte
// DAT_LO | waiting for data word low byte, word written next cycle
// CHK    | waiting for checksum byte
// DONE   | one-cycle completion pulse
// ERR    | one-cycle error exit, err_out stays set
module pram_loader
   import pram_loader_defs::*;
#(
   parameter int data_wl = 16,
   parameter int adr_wl  = 12
) (
   input  logic               clk,
   input  logic               a_reset,
   input  logic               start_load_in,
   input  logic [7:0]         rx_data_in,
   input  logic               rx_valid_in,
   input  logic               ovr_in,
   output logic               init_mode_out,
   output logic               init_ack_out,
   output logic [data_wl-1:0] data_out,
   output logic               busy_out,
   output logic               done_out,
   output logic               err_out,
   output logic [1:0]         err_code_out
);

   localparam int          CNT_W = adr_wl + 1;
   localparam logic [16:0] MAX_N = 17'(max_words(adr_wl));

   state_t          state, state_n;
   err_code_t       err_cause, code_q;
   logic            err_q;
   logic [7:0]      len_hi_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]     len_n;
   logic [7:0]      checksum;
   logic            load_active, ovr_hit;
   logic            hi_we, lo_we, chk_clr;

   assign len_n       = {len_hi_q, rx_data_in};
   assign load_active = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DAT_HI) ||
                        (state == S_DAT_LO) || (state == S_CHK);
   assign ovr_hit     = ovr_in && load_active;

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      err_cause = ERR_NONE;
      case (state)
         S_IDLE:   if (start_load_in) state_n = S_LEN_HI;
         S_LEN_HI: if (rx_valid_in) state_n = S_LEN_LO;
         S_LEN_LO: begin
            if (rx_valid_in) begin
               if ({1'b0, len_n} > MAX_N) begin
                  state_n   = S_ERR;
                  err_cause = ERR_LEN;
               end else if (len_n == 16'd0) begin
                  state_n = S_CHK;
               end else begin
                  state_n = S_DAT_HI;
               end
            end
         end
         S_DAT_HI: if (rx_valid_in) state_n = S_DAT_LO;
         S_DAT_LO: begin
            if (rx_valid_in)
               state_n = (cnt_q == CNT_W'(1)) ? S_CHK : S_DAT_HI;
         end
         S_CHK: begin
            if (rx_valid_in) begin
               if (rx_data_in == checksum) begin
                  state_n = S_DONE;
               end else begin
                  state_n   = S_ERR;
                  err_cause = ERR_CHK;
               end
            end
         end
         S_DONE:   state_n = S_IDLE;
         S_ERR:    state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
      // Overflow from the address counter pre-empts whatever byte arrived this cycle.
      if (ovr_hit) begin
         state_n   = S_ERR;
         err_cause = ERR_OVR;
      end
   end

   always_comb begin
      init_mode_out = load_active;
      busy_out      = load_active;
      done_out      = (state == S_DONE);
      chk_clr       = (state == S_IDLE) && start_load_in;
      hi_we         = (state == S_DAT_HI) && rx_valid_in && !ovr_hit;
      lo_we         = (state == S_DAT_LO) && rx_valid_in && !ovr_hit;
   end

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         len_hi_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         if ((state == S_LEN_HI) && rx_valid_in && !ovr_hit)
            len_hi_q <= rx_data_in;
         if ((state == S_LEN_LO) && rx_valid_in && !ovr_hit)
            cnt_q <= len_n[CNT_W-1:0];
         else if (lo_we)
            cnt_q <= cnt_q - CNT_W'(1);
         if (chk_clr) begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
         end else if ((state_n == S_ERR) && (state != S_ERR)) begin
            err_q  <= 1'b1;
            code_q <= err_cause;
         end
      end
   end

   assign err_out      = err_q;
   assign err_code_out = code_q;

   pram_loader_asm #(.data_wl(data_wl)) u_asm (
      .clk          (clk),
      .a_reset      (a_reset),
      .chk_clr      (chk_clr),
      .hi_we        (hi_we),
      .lo_we        (lo_we),
      .rx_data_in   (rx_data_in),
      .data_out     (data_out),
      .init_ack_out (init_ack_out),
      .checksum     (checksum)
   );

endmodule

// File: tb/tb_pram_loader.sv
// Scoreboard bench for pram_loader: expected words are queued as LO bytes are sent
// and compared when init_ack_out fires; frame outcomes are checked per test.
module tb_pram_loader;

   logic        clk = 1'b0;
   logic        a_reset;
   logic        start_load_in;
   logic [7:0]  rx_data_in;
   logic        rx_valid_in;
   logic        ovr_in;
   logic        init_mode_out;
   logic        init_ack_out;
   logic [15:0] data_out;
   logic        busy_out;
   logic        done_out;
   logic        err_out;
   logic [1:0]  err_code_out;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ack_cnt  = 0;
   int          ack_base;
   logic        prev_ack = 1'b0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_word;
   logic [15:0] words[16];

   always #5 clk = ~clk;

   pram_loader #(.data_wl(16), .adr_wl(12)) dut (
      .clk           (clk),
      .a_reset       (a_reset),
      .start_load_in (start_load_in),
      .rx_data_in    (rx_data_in),
      .rx_valid_in   (rx_valid_in),
      .ovr_in        (ovr_in),
      .init_mode_out (init_mode_out),
      .init_ack_out  (init_ack_out),
      .data_out      (data_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .err_out       (err_out),
      .err_code_out  (err_code_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (init_ack_out) begin
         check("ack_spacing", {31'd0, prev_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_word = exp_q.pop_front();
            check("ack_data", {16'd0, data_out}, {16'd0, exp_word});
         end
         ack_cnt++;
      end
      prev_ack = init_ack_out;
   end

   task automatic send_byte(input logic [7:0] b, input logic with_ovr = 1'b0);
      @(negedge clk);
      rx_data_in  = b;
      rx_valid_in = 1'b1;
      ovr_in      = with_ovr;
      @(negedge clk);
      rx_valid_in = 1'b0;
      ovr_in      = 1'b0;
   endtask

   task automatic do_start(input logic with_rx);
      @(negedge clk);
      start_load_in = 1'b1;
      if (with_rx) begin
         rx_data_in  = 8'hFF;
         rx_valid_in = 1'b1;
      end
      @(negedge clk);
      start_load_in = 1'b0;
      rx_valid_in   = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] n, input int nsend, input logic [7:0] chk_mask,
                             input logic send_chk);
      logic [7:0] x = 8'h00;
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      for (int i = 0; i < nsend; i++) begin
         send_byte(words[i][15:8]);
         exp_q.push_back(words[i]);
         send_byte(words[i][7:0]);
         x = x ^ words[i][15:8] ^ words[i][7:0];
      end
      if (send_chk)
         send_byte(x ^ chk_mask);
   endtask

   task automatic wait_end(input logic exp_done, input logic [1:0] exp_code, input string tag);
      int i;
      for (i = 0; i < 20; i++) begin
         if (done_out || err_out) break;
         @(negedge clk);
      end
      check({tag, "_timeout"}, (i < 20) ? 32'd1 : 32'd0, 32'd1);
      check({tag, "_done"}, {31'd0, done_out}, {31'd0, exp_done});
      check({tag, "_err"}, {31'd0, err_out}, {31'd0, !exp_done});
      check({tag, "_code"}, {30'd0, err_code_out}, {30'd0, exp_code});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done_out}, 32'd0);
      check({tag, "_init_mode_off"}, {31'd0, init_mode_out}, 32'd0);
      check({tag, "_busy_off"}, {31'd0, busy_out}, 32'd0);
      check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_init_mode"}, {31'd0, init_mode_out}, 32'd0);
      check({tag, "_ack"}, {31'd0, init_ack_out}, 32'd0);
      check({tag, "_data"}, {16'd0, data_out}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
      check({tag, "_done"}, {31'd0, done_out}, 32'd0);
      check({tag, "_err"}, {31'd0, err_out}, 32'd0);
      check({tag, "_code"}, {30'd0, err_code_out}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_reset       = 1'b1;
      start_load_in = 1'b0;
      rx_data_in    = 8'h00;
      rx_valid_in   = 1'b0;
      ovr_in        = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      a_reset = 1'b0;

      // Bytes in IDLE are ignored
      send_byte(8'h00);
      check("idle_rx_busy", {31'd0, busy_out}, 32'd0);

      // Two-word frame
      words[0] = 16'h1234;
      words[1] = 16'hABCD;
      ack_base = ack_cnt;
      do_start(1'b0);
      check("t1_init_mode_on", {31'd0, init_mode_out}, 32'd1);
      check("t1_busy_on", {31'd0, busy_out}, 32'd1);
      send_frame(16'd2, 2, 8'h00, 1'b1);
      wait_end(1'b1, 2'd0, "t1");
      check("t1_ack_count", ack_cnt - ack_base, 32'd2);
      check("t1_data_hold", {16'd0, data_out}, 32'h0000ABCD);

      // Empty image
      ack_base = ack_cnt;
      do_start(1'b0);
      send_frame(16'd0, 0, 8'h00, 1'b1);
      wait_end(1'b1, 2'd0, "t2");
      check("t2_ack_count", ack_cnt - ack_base, 32'd0);

      // Length one past the maximum
      ack_base = ack_cnt;
      do_start(1'b0);
      send_frame(16'h1001, 0, 8'h00, 1'b0);
      wait_end(1'b0, 2'd1, "t3");
      check("t3_ack_count", ack_cnt - ack_base, 32'd0);

      // Exactly the maximum length is accepted; abort with reset afterwards
      do_start(1'b0);
      send_byte(8'h10);
      send_byte(8'h00);
      check("max_len_err", {31'd0, err_out}, 32'd0);
      check("max_len_busy", {31'd0, busy_out}, 32'd1);
      #2 a_reset = 1'b1;
      #1 check_all_zero("max_len_rst");
      @(negedge clk);
      a_reset = 1'b0;

      // Bad checksum: sent 00, correct value FF
      words[0] = 16'h55AA;
      ack_base = ack_cnt;
      do_start(1'b0);
      send_frame(16'd1, 1, 8'hFF, 1'b1);
      wait_end(1'b0, 2'd2, "t4");
      check("t4_ack_count", ack_cnt - ack_base, 32'd1);

      // Reset mid-load, then a full reload
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
      do_start(1'b0);
      check("t5_err_cleared", {31'd0, err_out}, 32'd0);
      check("t5_code_cleared", {30'd0, err_code_out}, 32'd0);
      send_frame(16'd8, 3, 8'h00, 1'b0);
      #2 a_reset = 1'b1;
      #1 check_all_zero("t5_rst");
      exp_q.delete();
      @(negedge clk);
      a_reset = 1'b0;
      ack_base = ack_cnt;
      do_start(1'b0);
      send_frame(16'd8, 8, 8'h00, 1'b1);
      wait_end(1'b1, 2'd0, "t5");
      check("t5_ack_count", ack_cnt - ack_base, 32'd8);

      // Overflow together with a LO byte strobe
      ack_base = ack_cnt;
      do_start(1'b0);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22, 1'b1);
      wait_end(1'b0, 2'd3, "t6");
      check("t6_ack_count", ack_cnt - ack_base, 32'd0);
      repeat (3) @(negedge clk);
      check("t6_err_sticky", {31'd0, err_out}, 32'd1);
      check("t6_code_sticky", {30'd0, err_code_out}, 32'd3);
      words[0] = 16'h1122;
      words[1] = 16'h3344;
      do_start(1'b0);
      check("t6_err_cleared", {31'd0, err_out}, 32'd0);
      send_frame(16'd2, 2, 8'h00, 1'b1);
      wait_end(1'b1, 2'd0, "t6b");

      // Start and rx strobe together: the byte is dropped
      words[0] = 16'hBEEF;
      ack_base = ack_cnt;
      do_start(1'b1);
      send_frame(16'd1, 1, 8'h00, 1'b1);
      wait_end(1'b1, 2'd0, "t7");
      check("t7_ack_count", ack_cnt - ack_base, 32'd1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pram_loader.md
Name: pram_loader

Overview:
- Source end of the pram_adr_cnt initialisation interface.
- Receives a byte stream from the host link (UART/byte receiver) and parses a framed program image. Packs bytes into data_wl-bit words and presents each word with a one-cycle init ack, so that pram_adr_cnt writes it into pram.
- Sits between the byte receiver and pram_adr_cnt. It owns init_mode for the whole load and reports completion or error to the top-level control.

Parameters:
- data_wl, 16, program word width; must be 16 (two bytes per word).
- adr_wl, 12, pram address width; the maximum image length is 2^adr_wl words.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- a_reset  in  1  asynchronous reset, active-high.
- start_load_in  in  1  one-cycle request to begin a load; sampled in IDLE only.
- rx_data_in  in  8  received byte.
- rx_valid_in  in  1  rx_data_in is valid this cycle; one-cycle strobe with no backpressure.
- ovr_in  in  1  overflow flag from pram_adr_cnt (ovr_out).
- init_mode_out  out  1  to pram_adr_cnt init_mode_in; high for the whole load.
- init_ack_out  out  1  to pram_adr_cnt init_ack_in; one-cycle pulse, data_out valid.
- data_out  out  data_wl  to pram_adr_cnt data_in1; assembled word.
- busy_out  out  1  a load is in progress (any state other than IDLE, DONE, ERR).
- done_out  out  1  one-cycle pulse on successful completion.
- err_out  out  1  sticky error flag; cleared by the next accepted start_load_in or by reset.
- err_code_out  out  2  error cause: 0 none, 1 length, 2 checksum, 3 overflow.

Behaviour:
- Frame format, bytes MSB first:
  - LEN_HI, LEN_LO: the word count N.
  - N words, each sent as HI byte then LO byte.
  - CHK: XOR of every byte after the header (data bytes only).
- Reset values: every output 0; FSM in IDLE; word counter, checksum and byte register all 0.
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE, ERR.
- IDLE:
  - start_load_in=1 → LEN_HI. In the same edge: init_mode_out=1, err_out=0, err_code_out=0, checksum=0.
- LEN_HI:
  - rx_valid_in → latch the length high byte → LEN_LO.
- LEN_LO:
  - rx_valid_in → latch the length low byte, forming N.
  - N > 2^adr_wl → ERR with code 1.
  - N == 0 → CHK.
  - Otherwise → DAT_HI, with the remaining-word counter set to N.
- DAT_HI:
  - rx_valid_in → store the byte, XOR it into the checksum → DAT_LO.
- DAT_LO:
  - rx_valid_in → data_out <= {hi, rx_data_in}, XOR the byte into the checksum.
  - init_ack_out=1 in the next cycle only (registered, latency 1 clk after the LO byte strobe).
  - Counter decrements. When the counter reaches 0 → CHK, else → DAT_HI.
- CHK:
  - rx_valid_in with byte == checksum → DONE.
  - Otherwise → ERR with code 2.
- DONE:
  - done_out=1 for one cycle, init_mode_out=0 → IDLE.
- ERR:
  - err_out=1 (sticky), init_mode_out=0, no further acks → IDLE in the next cycle.
- Overflow:
  - ovr_in=1 while init_mode_out=1 → ERR with code 3, from any state.
  - This has priority over the byte handling in the same cycle.
- data_out holds its value between acks.
- Ack spacing: init_ack_out is never high in two consecutive cycles. The ack rate is at most one per two rx strobes.
- Word width: the counter is adr_wl+1 bits wide so that N = 2^adr_wl is representable.
- Ignored inputs:
  - rx_valid_in in IDLE, DONE or ERR is ignored.
  - start_load_in outside IDLE is ignored.
- Simultaneous events:
  - rx_valid_in and start_load_in in the same IDLE cycle: the byte is dropped; the frame starts with the next byte.
- Reset mid-load: immediate return to IDLE, init_mode_out=0, and no pulse on done_out or err_out.

Decomposition:
- Shared package/include pram_loader_defs:
  - state encodings (3 bits);
  - error codes: ERR_NONE, ERR_LEN, ERR_CHK, ERR_OVR;
  - MAX_WORDS = 2^adr_wl.
- One sub-module, pram_loader_asm: the byte-to-word assembler.
  - Holds the hi-byte register, the checksum XOR accumulator and the registered ack pulse.
  - The FSM and the counter stay in pram_loader.

Test Plan:
- Frame 00 02 | 12 34 | AB CD | CHK=12^34^AB^CD=40 → two acks with data_out=0x1234 then 0xABCD; one done_out pulse; err_out=0; init_mode_out low after DONE.
- Frame 00 00 | CHK=00 → no ack; done_out pulse; image loaded with 0 words.
- Frame 10 01 (N=4097 with adr_wl=12) → ERR immediately after LEN_LO; err_code_out=1; no ack; init_mode_out=0.
- Frame 00 01 | 55 AA | CHK=00 (expected FF) → one ack with 0x55AA, then err_out=1 and err_code_out=2; no done_out.
- Assert a_reset after 3 data words of an N=8 frame → all outputs 0 asynchronously. A new start_load_in followed by a full frame then loads correctly from word 0.
- ovr_in pulsed during DAT_LO with a simultaneous rx strobe → ERR with code 3; no ack for that byte; err_out stays 1 until the next start_load_in.
